// File: rtl/soc_cops_sqrt_axi_client.sv
// rtl/soc_cops_sqrt_axi_client.sv - AXI master client that pushes an operand to the square-root engine, polls status and pops the result
// Optional build macro: COPS_CLIENT_TIMEOUT_EN (abort with an error after 256 not-ready status polls)
module soc_cops_sqrt_axi_client #(
    parameter logic [31:0] OP_ADDR   = 32'h1FD004F0,
    parameter logic [31:0] STAT_ADDR = 32'h1FD004F4,
    parameter logic [3:0]  AXI_ID    = 4'h0,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,

    output logic [3:0]  axi_m_awid,
    output logic [31:0] axi_m_awaddr,
    output logic [7:0]  axi_m_awlen,
    output logic [2:0]  axi_m_awsize,
    output logic [1:0]  axi_m_awburst,
    output logic        axi_m_awuser,
    output logic        axi_m_awvalid,
    input  logic        axi_m_awready,

    output logic [31:0] axi_m_wdata,
    output logic [3:0]  axi_m_wstrb,
    output logic        axi_m_wlast,
    output logic        axi_m_wvalid,
    input  logic        axi_m_wready,

    input  logic [3:0]  axi_m_bid,
    input  logic [1:0]  axi_m_bresp,
    input  logic        axi_m_bvalid,
    output logic        axi_m_bready,

    output logic [3:0]  axi_m_arid,
    output logic [31:0] axi_m_araddr,
    output logic [7:0]  axi_m_arlen,
    output logic [2:0]  axi_m_arsize,
    output logic [1:0]  axi_m_arburst,
    output logic        axi_m_aruser,
    output logic        axi_m_arvalid,
    input  logic        axi_m_arready,

    input  logic [3:0]  axi_m_rid,
    input  logic [31:0] axi_m_rdata,
    input  logic [1:0]  axi_m_rresp,
    input  logic        axi_m_rlast,
    input  logic        axi_m_rvalid,
    output logic        axi_m_rready
);

    typedef enum logic [3:0] {
        IDLE,
        WR,
        WRESP,
        PAR,
        PR,
        GAP,
        DAR,
        DR,
        RSP
    } state_t;

    // GAP is entered with POLL_GAP-1 and leaves when the counter reads zero,
    // so it occupies exactly POLL_GAP cycles.
    localparam logic [3:0] GAP_LOAD = (POLL_GAP == 0) ? 4'd0 : 4'(POLL_GAP - 1);

    state_t      state;
    state_t      state_n;
    logic [31:0] rsp_data_n;
    logic        rsp_err_n;
    logic        aw_done;
    logic        w_done;
    logic        aw_fin;
    logic        w_fin;
    logic        poll_to;
    logic [3:0]  gap_cnt;

`ifdef COPS_CLIENT_TIMEOUT_EN
    logic [7:0]  poll_cnt;
`endif

    // Single beat, full-word, INCR bursts; IDs and user bits are constant.
    assign axi_m_awid    = AXI_ID;
    assign axi_m_awlen   = 8'd0;
    assign axi_m_awsize  = 3'd2;
    assign axi_m_awburst = 2'd1;
    assign axi_m_awuser  = 1'b0;
    assign axi_m_wstrb   = 4'hF;
    assign axi_m_wlast   = 1'b1;
    assign axi_m_arid    = AXI_ID;
    assign axi_m_arlen   = 8'd0;
    assign axi_m_arsize  = 3'd2;
    assign axi_m_arburst = 2'd1;
    assign axi_m_aruser  = 1'b0;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state selection and the response value captured on entry to RSP.
    always_comb begin
        state_n    = state;
        rsp_data_n = rsp_data;
        rsp_err_n  = rsp_err;
        aw_fin     = aw_done | (axi_m_awvalid & axi_m_awready);
        w_fin      = w_done  | (axi_m_wvalid  & axi_m_wready);
        poll_to    = 1'b0;
`ifdef COPS_CLIENT_TIMEOUT_EN
        poll_to    = (poll_cnt == 8'hFF);
`endif
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_n = WR;
                end
            end
            WR: begin
                if (aw_fin && w_fin) begin
                    state_n = WRESP;
                end
            end
            WRESP: begin
                if (axi_m_bvalid && axi_m_bready) begin
                    if (axi_m_bresp == 2'b00) begin
                        state_n = PAR;
                    end else begin
                        state_n    = RSP;
                        rsp_data_n = 32'h0;
                        rsp_err_n  = 1'b1;
                    end
                end
            end
            PAR: begin
                if (axi_m_arvalid && axi_m_arready) begin
                    state_n = PR;
                end
            end
            PR: begin
                if (axi_m_rvalid && axi_m_rready) begin
                    if (axi_m_rresp != 2'b00) begin
                        state_n    = RSP;
                        rsp_data_n = 32'h0;
                        rsp_err_n  = 1'b1;
                    end else if (axi_m_rdata[0]) begin
                        state_n = DAR;
                    end else if (poll_to) begin
                        state_n    = RSP;
                        rsp_data_n = 32'hFFFFFFFF;
                        rsp_err_n  = 1'b1;
                    end else if (POLL_GAP == 0) begin
                        state_n = PAR;
                    end else begin
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_n = PAR;
                end
            end
            DAR: begin
                if (axi_m_arvalid && axi_m_arready) begin
                    state_n = DR;
                end
            end
            DR: begin
                if (axi_m_rvalid && axi_m_rready) begin
                    state_n    = RSP;
                    rsp_data_n = axi_m_rdata;
                    rsp_err_n  = (axi_m_rresp != 2'b00);
                end
            end
            RSP: begin
                if (rsp_valid && rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered handshake outputs, addresses and response, derived from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= 32'h0;
            rsp_err       <= 1'b0;
            axi_m_awaddr  <= 32'h0;
            axi_m_awvalid <= 1'b0;
            axi_m_wdata   <= 32'h0;
            axi_m_wvalid  <= 1'b0;
            axi_m_bready  <= 1'b0;
            axi_m_araddr  <= 32'h0;
            axi_m_arvalid <= 1'b0;
            axi_m_rready  <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            gap_cnt       <= 4'd0;
        end else begin
            req_ready    <= (state_n == IDLE);
            axi_m_bready <= (state_n == WRESP);
            axi_m_rready <= (state_n == PR) || (state_n == DR);
            rsp_valid    <= (state_n == RSP);
            rsp_data     <= rsp_data_n;
            rsp_err      <= rsp_err_n;

            // Address and data channels of the write run independently and
            // each drops its valid right after its own handshake.
            if (state != WR && state_n == WR) begin
                axi_m_awaddr  <= OP_ADDR;
                axi_m_awvalid <= 1'b1;
                axi_m_wdata   <= req_data;
                axi_m_wvalid  <= 1'b1;
                aw_done       <= 1'b0;
                w_done        <= 1'b0;
            end else begin
                if (axi_m_awvalid && axi_m_awready) begin
                    axi_m_awvalid <= 1'b0;
                    aw_done       <= 1'b1;
                end
                if (axi_m_wvalid && axi_m_wready) begin
                    axi_m_wvalid <= 1'b0;
                    w_done       <= 1'b1;
                end
            end

            // Status and data reads share the AR channel; only the address differs.
            if ((state_n == PAR || state_n == DAR) && state_n != state) begin
                axi_m_arvalid <= 1'b1;
                axi_m_araddr  <= (state_n == DAR) ? OP_ADDR : STAT_ADDR;
            end else if (axi_m_arvalid && axi_m_arready) begin
                axi_m_arvalid <= 1'b0;
            end

            if (state_n == GAP && state != GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end

`ifdef COPS_CLIENT_TIMEOUT_EN
    // Completed status polls since the operand write began.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= 8'd0;
        end else if (state_n == WR && state != WR) begin
            poll_cnt <= 8'd0;
        end else if (state == PR && axi_m_rvalid && axi_m_rready) begin
            poll_cnt <= poll_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_soc_cops_sqrt_axi_client.sv
// tb/tb_soc_cops_sqrt_axi_client.sv - scoreboard bench for soc_cops_sqrt_axi_client with a directed AXI slave model
`timescale 1ns/1ps
module tb_soc_cops_sqrt_axi_client;

    localparam logic [31:0] OP_ADDR   = 32'h1FD004F0;
    localparam logic [31:0] STAT_ADDR = 32'h1FD004F4;
    localparam int          POLL_GAP  = 4;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready;
    logic [31:0] req_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awuser, aruser, awvalid, awready, wvalid, wready, wlast;
    logic [3:0]  wstrb;
    logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t        sb_q[$];
    logic [31:0] stat_q[$];
    int          stat_cyc[$];
    logic [31:0] exp_operand;
    logic [31:0] cfg_data;
    logic [1:0]  cfg_bresp, cfg_rresp;
    int          aw_lat, w_lat, ar_lat, rsp_hold;
    int          aw_hs, w_hs, b_hs, stat_reads, data_reads, rsp_seen, cyc;

    int          aw_cnt, w_cnt, ar_cnt;
    bit          aw_fired, w_fired, ar_fired, b_fired, r_fired, b_due, r_due, aw_tx, w_tx;
    logic [31:0] r_data_q;
    logic [1:0]  r_resp_q;

    always #5 clk = ~clk;

    soc_cops_sqrt_axi_client #(
        .OP_ADDR(OP_ADDR), .STAT_ADDR(STAT_ADDR), .AXI_ID(4'h0), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .axi_m_awid(awid), .axi_m_awaddr(awaddr), .axi_m_awlen(awlen), .axi_m_awsize(awsize),
        .axi_m_awburst(awburst), .axi_m_awuser(awuser), .axi_m_awvalid(awvalid), .axi_m_awready(awready),
        .axi_m_wdata(wdata), .axi_m_wstrb(wstrb), .axi_m_wlast(wlast), .axi_m_wvalid(wvalid), .axi_m_wready(wready),
        .axi_m_bid(bid), .axi_m_bresp(bresp), .axi_m_bvalid(bvalid), .axi_m_bready(bready),
        .axi_m_arid(arid), .axi_m_araddr(araddr), .axi_m_arlen(arlen), .axi_m_arsize(arsize),
        .axi_m_arburst(arburst), .axi_m_aruser(aruser), .axi_m_arvalid(arvalid), .axi_m_arready(arready),
        .axi_m_rid(rid), .axi_m_rdata(rdata), .axi_m_rresp(rresp), .axi_m_rlast(rlast),
        .axi_m_rvalid(rvalid), .axi_m_rready(rready)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic void clear_counts();
        aw_hs = 0; w_hs = 0; b_hs = 0; stat_reads = 0; data_reads = 0; rsp_seen = 0;
        stat_cyc.delete();
    endfunction

    // AXI slave model: all decisions at negedge, so a handshake counted here happens at the next posedge.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 1;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_fired = 0; w_fired = 0; ar_fired = 0; b_fired = 0; r_fired = 0;
                b_due = 0; r_due = 0; aw_tx = 0; w_tx = 0;
                continue;
            end
            if (r_fired) begin
                rvalid = 0; r_fired = 0;
            end else if (r_due) begin
                rvalid = 1; rdata = r_data_q; rresp = r_resp_q;
                if (rready) begin r_fired = 1; r_due = 0; end
            end
            if (b_fired) begin
                bvalid = 0; b_fired = 0;
            end else if (b_due) begin
                bvalid = 1; bresp = cfg_bresp;
                if (bready) begin b_fired = 1; b_due = 0; b_hs++; end
            end
            if (aw_fired) begin
                awready = 0; aw_fired = 0;
                check("awvalid_drop", {31'd0, awvalid}, 32'd0);
            end else if (awvalid) begin
                aw_cnt++;
                if (aw_cnt >= aw_lat) begin
                    awready = 1; aw_fired = 1; aw_cnt = 0; aw_hs++; aw_tx = 1;
                    check("awaddr", awaddr, OP_ADDR);
                end
            end
            if (w_fired) begin
                wready = 0; w_fired = 0;
                check("wvalid_drop", {31'd0, wvalid}, 32'd0);
            end else if (wvalid) begin
                w_cnt++;
                if (w_cnt >= w_lat) begin
                    wready = 1; w_fired = 1; w_cnt = 0; w_hs++; w_tx = 1;
                    check("wdata", wdata, exp_operand);
                end
            end
            if (aw_tx && w_tx) begin
                b_due = 1; aw_tx = 0; w_tx = 0;
            end
            if (ar_fired) begin
                arready = 0; ar_fired = 0;
                check("arvalid_drop", {31'd0, arvalid}, 32'd0);
            end else if (arvalid) begin
                ar_cnt++;
                if (ar_cnt >= ar_lat) begin
                    arready = 1; ar_fired = 1; ar_cnt = 0; r_due = 1;
                    if (araddr == STAT_ADDR) begin
                        stat_reads++;
                        stat_cyc.push_back(cyc);
                        r_data_q = (stat_q.size() != 0) ? stat_q.pop_front() : 32'h0;
                        r_resp_q = 2'b00;
                    end else begin
                        data_reads++;
                        check("araddr_data", araddr, OP_ADDR);
                        r_data_q = cfg_data;
                        r_resp_q = cfg_rresp;
                    end
                end
            end
        end
    end

    // Response monitor: holds off rsp_ready as configured, then pops the scoreboard.
    initial begin
        logic [31:0] hd;
        logic        he;
        int          hold;
        bit          holding, acc;
        rsp_ready = 0; holding = 0; acc = 0; hold = 0; hd = 0; he = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rsp_ready = 0; holding = 0; acc = 0;
                continue;
            end
            if (acc) begin
                rsp_ready = 0; acc = 0;
                check("rsp_valid_dropped", {31'd0, rsp_valid}, 32'd0);
                check("idle_after_rsp", {31'd0, req_ready}, 32'd1);
            end else if (rsp_valid) begin
                rsp_seen++;
                if (!holding) begin
                    holding = 1; hold = rsp_hold; hd = rsp_data; he = rsp_err;
                end else begin
                    check("rsp_data_stable", rsp_data, hd);
                    check("rsp_err_stable", {31'd0, rsp_err}, {31'd0, he});
                end
                check("req_ready_busy", {31'd0, req_ready}, 32'd0);
                if (hold > 0) begin
                    hold--;
                end else begin
                    rsp_ready = 1; acc = 1; holding = 0;
                    if (sb_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_rsp: got data %h err %b, expected none", rsp_data, rsp_err);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input bit expect_rsp, input logic [31:0] ed, input logic ee);
        int t;
        t = 0;
        exp_operand = d;
        if (expect_rsp) sb_q.push_back('{ed, ee});
        @(negedge clk);
        req_valid = 1; req_data = d;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL req_accept_timeout: got req_ready 0, expected 1");
        end
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while ((sb_q.size() != 0 || !req_ready) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: got %0d pending responses, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 0; req_data = 0;
        aw_lat = 1; w_lat = 1; ar_lat = 1; rsp_hold = 0;
        cfg_data = 0; cfg_bresp = 0; cfg_rresp = 0; exp_operand = 0;
        clear_counts();

        reset = 1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("tie_awsize_burst", {27'd0, awsize, awburst}, {27'd0, 3'd2, 2'd1});
        check("tie_wstrb_wlast", {27'd0, wstrb, wlast}, {27'd0, 4'hF, 1'b1});
        reset = 0;
        @(posedge clk); #1;
        check("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Nominal: status 0,0,1 then result 4.
        clear_counts();
        stat_q = '{32'h0, 32'h0, 32'h1};
        cfg_data = 32'd4;
        send(32'd16, 1, 32'd4, 1'b0);
        wait_done(2000);
        check("t030_aw", aw_hs, 1);
        check("t030_w", w_hs, 1);
        check("t030_b", b_hs, 1);
        check("t030_stat_reads", stat_reads, 3);
        check("t030_data_reads", data_reads, 1);
        if (stat_cyc.size() >= 2)
            check("t030_poll_interval", stat_cyc[1] - stat_cyc[0], POLL_GAP + 2);

        // Address accepted before data, then data before address.
        clear_counts();
        aw_lat = 1; w_lat = 3;
        stat_q = '{32'h1};
        cfg_data = 32'd9;
        send(32'd81, 1, 32'd9, 1'b0);
        wait_done(2000);
        check("t031_aw", aw_hs, 1);
        check("t031_w", w_hs, 1);
        clear_counts();
        aw_lat = 3; w_lat = 1;
        stat_q = '{32'h1};
        cfg_data = 32'd12;
        send(32'd144, 1, 32'd12, 1'b0);
        wait_done(2000);
        check("t031b_aw", aw_hs, 1);
        check("t031b_w", w_hs, 1);
        aw_lat = 1; w_lat = 1;

        // Write error response: no reads, error result.
        clear_counts();
        cfg_bresp = 2'b10;
        send(32'h0000DEAD, 1, 32'h0, 1'b1);
        wait_done(2000);
        check("t032_no_reads", stat_reads + data_reads, 0);
        check("t032_b", b_hs, 1);
        cfg_bresp = 2'b00;

        // Consumer stalls the response for five cycles.
        clear_counts();
        rsp_hold = 5;
        stat_q = '{32'h1};
        cfg_data = 32'h00001234;
        send(32'h014B5A90, 1, 32'h00001234, 1'b0);
        wait_done(2000);
        check("t033_rsp_cycles", rsp_seen, 6);
        rsp_hold = 0;

        // Data read with slave error; status with only upper bits set is not ready.
        clear_counts();
        stat_q = '{32'h2, 32'hFFFFFFFF};
        cfg_data = 32'd55;
        cfg_rresp = 2'b10;
        send(32'd3025, 1, 32'd55, 1'b1);
        wait_done(2000);
        check("t_rresp_stat_reads", stat_reads, 2);
        cfg_rresp = 2'b00;

        // Reset in the middle of a status read.
        clear_counts();
        stat_q.delete();
        send(32'd7, 0, 32'd0, 1'b0);
        begin
            int t;
            t = 0;
            while (!rready && t < 200) begin
                @(negedge clk);
                t++;
            end
            check("t034_reached_pr", {31'd0, rready}, 32'd1);
        end
        #2 reset = 1;
        #1;
        check("t034_valids_low", {26'd0, awvalid, wvalid, arvalid, rready, bready, rsp_valid}, 32'd0);
        check("t034_req_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        check("t034_req_ready_release", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

`ifdef COPS_CLIENT_TIMEOUT_EN
        // Status never ready: exactly 256 polls then timeout error.
        clear_counts();
        stat_q.delete();
        send(32'd99, 1, 32'hFFFFFFFF, 1'b1);
        wait_done(5000);
        check("t035_stat_reads", stat_reads, 256);
        check("t035_data_reads", data_reads, 0);
`endif

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
